// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the writeback arbiter.
//   - funct3 encodings of the load types
//   - wb_entry_t: one pending register-file write {rd, data}
//   - ld_extend(): byte/halfword select plus sign/zero extension of a load word
package wb_pkg;

    localparam int WB_DLEN = 32;
    localparam int WB_ALEN = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_ALEN-1:0] rd;
        logic [WB_DLEN-1:0] data;
    } wb_entry_t;

    // Unknown funct3 values fall through to a full-word load.
    function automatic logic [WB_DLEN-1:0] ld_extend(input logic [WB_DLEN-1:0] data,
                                                     input logic [2:0]         funct3,
                                                     input logic [1:0]         off);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [WB_DLEN-1:0] r;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_LB:   r = {{(WB_DLEN-8){b[7]}}, b};
            F3_LBU:  r = {{(WB_DLEN-8){1'b0}}, b};
            F3_LH:   r = {{(WB_DLEN-16){h[15]}}, h};
            F3_LHU:  r = {{(WB_DLEN-16){1'b0}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t.
//   clk, rst_n          clock, async active-low reset (empties the queue)
//   push, push_data     enqueue request and entry (ignored when full)
//   pop                 dequeue request (ignored when empty)
//   head                entry at the read pointer
//   full, empty, count  registered occupancy status
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_entry_t     push_data,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= AW'(wptr + 1'b1);
            if (do_pop)  rptr <= AW'(rptr + 1'b1);
            case ({do_push, do_pop})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage owning the register file write port.
//   clk, rst_n                        clock, async active-low reset
//   i_alu_valid/o_alu_ready           ALU result handshake (rd, data)
//   i_ld_valid/o_ld_ready             load response handshake (rd, raw word, funct3, byte offset)
//   o_wen, o_waddr, o_wdata           registered write, also the forwarding source
//   o_ld_pending                      load queue occupancy for the hazard unit
// Loads are extended on entry and queued; the queue head beats the ALU
// until MAX_LD_STREAK loads have gone through while the ALU waited.
// DLEN/ALEN must match the widths in wb_pkg.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DLEN          = WB_DLEN,
    parameter int ALEN          = WB_ALEN,
    parameter int LQ_DEPTH      = 4,
    parameter int MAX_LD_STREAK = 3,
    localparam int CW = $clog2(LQ_DEPTH + 1),
    localparam int SW = (MAX_LD_STREAK < 1) ? 1 : $clog2(MAX_LD_STREAK + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [ALEN-1:0] i_alu_rd,
    input  logic [DLEN-1:0] i_alu_data,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [ALEN-1:0] i_ld_rd,
    input  logic [DLEN-1:0] i_ld_data,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_off,
    output logic            o_wen,
    output logic [ALEN-1:0] o_waddr,
    output logic [DLEN-1:0] o_wdata,
    output logic [CW-1:0]   o_ld_pending
);

    wb_entry_t     ld_in, head, sel;
    logic          full, empty;
    logic          alu_take, pop, sel_valid, streak_hit;
    logic [SW-1:0] streak;

    assign ld_in = '{rd: i_ld_rd, data: ld_extend(i_ld_data, i_ld_funct3, i_ld_off)};

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_ld_valid),
        .push_data (ld_in),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (o_ld_pending)
    );

    // Both readies come from registered state only: a pop this cycle never
    // frees a slot for a push this cycle, and ALU ready ignores ALU valid.
    assign o_ld_ready  = !full;
    assign streak_hit  = (streak == SW'(MAX_LD_STREAK));
    assign o_alu_ready = empty || streak_hit;
    assign alu_take    = i_alu_valid && o_alu_ready;
    assign pop         = !empty && !alu_take;
    assign sel_valid   = alu_take || pop;

    always_comb begin
        sel = head;
        if (alu_take) sel = '{rd: i_alu_rd, data: i_alu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wen   <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            streak  <= '0;
        end else begin
            // x0 targets are consumed silently; address/data keep the last real write.
            o_wen <= sel_valid && (sel.rd != '0);
            if (sel_valid && (sel.rd != '0)) begin
                o_waddr <= sel.rd;
                o_wdata <= sel.data;
            end
            // Only loads that overtook a waiting ALU result count toward the streak.
            if (!i_alu_valid || alu_take) streak <= '0;
            else if (pop)                 streak <= SW'(streak + 1'b1);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Two instances share data buses:
// dut uses the default streak limit (3); dut_f uses a limit of 0, which
// gives a valid ALU strict priority so the load queue can be filled.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid, ld_valid, f_alu_valid, f_ld_valid;
    logic [4:0]  alu_rd, ld_rd;
    logic [31:0] alu_data, ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;

    logic        alu_ready, ld_ready, wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  pending;
    logic        f_alu_ready, f_ld_ready, f_wen;
    logic [4:0]  f_waddr;
    logic [31:0] f_wdata;
    logic [2:0]  f_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
        .i_ld_funct3(ld_funct3), .i_ld_off(ld_off),
        .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata), .o_ld_pending(pending)
    );

    wb_arbiter #(.MAX_LD_STREAK(0)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .i_alu_valid(f_alu_valid), .o_alu_ready(f_alu_ready), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .i_ld_valid(f_ld_valid), .o_ld_ready(f_ld_ready), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
        .i_ld_funct3(ld_funct3), .i_ld_off(ld_off),
        .o_wen(f_wen), .o_waddr(f_waddr), .o_wdata(f_wdata), .o_ld_pending(f_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data,
                            input logic [2:0] f3, input logic [1:0] off);
        ld_rd = rd; ld_data = data; ld_funct3 = f3; ld_off = off;
    endtask

    // Enqueue one load into an idle, empty dut and check the write two edges later.
    task automatic ld_case(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] exp);
        drive_ld(rd, 32'h80FF7F01, f3, off);
        ld_valid = 1'b1;
        chk({tag, "_ready"}, ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        chk({tag, "_pend1"}, pending, 1);
        chk({tag, "_wen0"}, wen, 0);
        tick();
        chk({tag, "_wen1"}, wen, 1);
        chk({tag, "_waddr"}, waddr, rd);
        chk({tag, "_wdata"}, wdata, exp);
        chk({tag, "_pend0"}, pending, 0);
    endtask

    initial begin
        alu_valid = 0; ld_valid = 0; f_alu_valid = 0; f_ld_valid = 0;
        alu_rd = 0; alu_data = 0;
        drive_ld(0, 0, F3_LW, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        rst_n = 1'b1;
        tick();
        tick();

        // ALU only
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        chk("alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("alu_wen", wen, 1);
        chk("alu_waddr", waddr, 5);
        chk("alu_wdata", wdata, 32'hDEADBEEF);
        tick();
        chk("alu_idle_wen", wen, 0);
        chk("alu_idle_waddr", waddr, 5);
        chk("alu_idle_wdata", wdata, 32'hDEADBEEF);

        // Load extension of 0x80FF7F01
        ld_case("lb1",  1, F3_LB,  1, 32'h0000007F);
        ld_case("lb3",  2, F3_LB,  3, 32'hFFFFFF80);
        ld_case("lhu2", 3, F3_LHU, 2, 32'h000080FF);
        ld_case("lh2",  4, F3_LH,  2, 32'hFFFF80FF);
        ld_case("lw",   5, F3_LW,  2, 32'h80FF7F01);

        // x0 suppression
        tick();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        chk("x0_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        chk("x0_alu_wen", wen, 0);
        drive_ld(0, 32'h5678, F3_LW, 0);
        ld_valid = 1;
        tick();
        ld_valid = 0;
        chk("x0_ld_pend1", pending, 1);
        chk("x0_ld_wen_a", wen, 0);
        tick();
        chk("x0_ld_pend0", pending, 0);
        chk("x0_ld_wen_b", wen, 0);
        tick();
        chk("x0_ld_wen_c", wen, 0);

        // Starvation on dut (limit 3): writes L11,L12,L13,A20,L14,L15
        drive_ld(11, 32'h111, F3_LW, 0);
        ld_valid = 1;
        chk("st_c0_alu_ready", alu_ready, 1);
        tick();
        chk("st_c0_pend", pending, 1);
        alu_valid = 1; alu_rd = 20; alu_data = 32'hA0;
        drive_ld(12, 32'h112, F3_LW, 0);
        chk("st_c1_alu_ready", alu_ready, 0);
        tick();
        chk("st_w1_wen", wen, 1);
        chk("st_w1_waddr", waddr, 11);
        chk("st_w1_wdata", wdata, 32'h111);
        drive_ld(13, 32'h113, F3_LW, 0);
        chk("st_c2_alu_ready", alu_ready, 0);
        tick();
        chk("st_w2_waddr", waddr, 12);
        drive_ld(14, 32'h114, F3_LW, 0);
        chk("st_c3_alu_ready", alu_ready, 0);
        tick();
        chk("st_w3_waddr", waddr, 13);
        drive_ld(15, 32'h115, F3_LW, 0);
        chk("st_c4_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0; ld_valid = 0;
        chk("st_w4_wen", wen, 1);
        chk("st_w4_waddr", waddr, 20);
        chk("st_w4_wdata", wdata, 32'hA0);
        chk("st_w4_pend", pending, 2);
        chk("st_c5_alu_ready", alu_ready, 0);
        tick();
        chk("st_w5_waddr", waddr, 14);
        chk("st_w5_wdata", wdata, 32'h114);
        chk("st_w5_pend", pending, 1);
        tick();
        chk("st_w6_waddr", waddr, 15);
        chk("st_w6_pend", pending, 0);
        tick();
        chk("st_idle_wen", wen, 0);

        // Full queue on dut_f: ALU held valid, so nothing pops
        f_alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        f_ld_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            drive_ld(5'(i), 32'h200 + i, F3_LW, 0);
            chk("full_ready_before", f_ld_ready, 1);
            chk("full_alu_ready", f_alu_ready, 1);
            tick();
            chk("full_pend", f_pending, 32'(i));
        end
        chk("full_ready_after4", f_ld_ready, 0);
        chk("full_alu_wen", f_wen, 1);
        chk("full_alu_waddr", f_waddr, 9);
        drive_ld(5, 32'h205, F3_LW, 0);
        tick();
        chk("full_5th_pend", f_pending, 4);
        chk("full_5th_ready", f_ld_ready, 0);
        f_alu_valid = 0; f_ld_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_wen", f_wen, 1);
            chk("drain_waddr", f_waddr, 32'(i));
            chk("drain_wdata", f_wdata, 32'h200 + i);
            chk("drain_pend", f_pending, 32'(4 - i));
        end
        tick();
        chk("drain_idle_wen", f_wen, 0);

        // Reset mid-stream on dut_f: two queued loads and a live write
        f_alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        f_ld_valid = 1;
        drive_ld(6, 32'h306, F3_LW, 0);
        tick();
        drive_ld(7, 32'h307, F3_LW, 0);
        tick();
        f_ld_valid = 0;
        chk("mid_pend2", f_pending, 2);
        chk("mid_wen1", f_wen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", f_wen, 0);
        chk("mid_rst_pend", f_pending, 0);
        chk("mid_rst_waddr", f_waddr, 0);
        chk("mid_rst_wdata", f_wdata, 0);
        chk("mid_rst_ld_ready", f_ld_ready, 1);
        f_alu_valid = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_wen_a", f_wen, 0);
        chk("post_rst_pend", f_pending, 0);
        tick();
        chk("post_rst_wen_b", f_wen, 0);
        chk("post_rst_main_wen", wen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
